bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter for the four shared-bus masters (m0..m3); produces the one-hot
//  m*_grant set that steers the master-side bus mux. Registered owner state; grant
//  held until owner drops its request. Sits between master request lines and the mux.
// PARAMETERS
//  MAX_HOLD  16  max cycles an owner may keep the bus while others wait (only with BUS_ARB_TIMEOUT_EN)
//  HOLD_W    5   width of hold counter; must hold MAX_HOLD (2**HOLD_W > MAX_HOLD)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset      in   1  asynchronous, active-high reset
//  m0_req     in   1  master 0 bus request, asserted == `REQ_ENABLE
//  m1_req     in   1  master 1 bus request
//  m2_req     in   1  master 2 bus request
//  m3_req     in   1  master 3 bus request
//  m_as       in   1  muxed address strobe from bus mux (`AS_ENABLE = transfer in progress)
//  m0_grant   out  1  master 0 grant, `GRANT_ENABLE when owner
//  m1_grant   out  1  master 1 grant
//  m2_grant   out  1  master 2 grant
//  m3_grant   out  1  master 3 grant
//  arb_owner  out  2  current owner index (debug/status)
// BEHAVIOUR
//  - One clock, reset asynchronous active-high. Reset: owner=0, m0_grant=`GRANT_ENABLE,
//    m1..m3_grant=`GRANT_DISABLE, arb_owner=2'd0, hold_cnt=0.
//  - Exactly one grant enabled at all times (bus always parked on some master); grants
//    decoded combinationally from registered owner, no glitch paths from req inputs.
//  - States = owner 0..3. Each edge: if owner's req == `REQ_ENABLE -> stay.
//    Else search owner+1, owner+2, owner+3 (mod 4, wrap 3->0); first requester becomes
//    owner. None requesting -> owner unchanged (park on last owner).
//  - Latency: owner deasserts req in cycle t -> new grant visible in cycle t+1. No dead cycle.
//  - Simultaneous requests resolved only by rotation order from current owner; owner's own
//    req re-asserted in same cycle as release is treated as still held.
//  - m_as ignored unless BUS_ARB_TIMEOUT_EN.
//  - Reset mid-transfer: owner forced to 0 immediately, counter cleared; no transfer recovery.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//   - hold_cnt increments each cycle owner is granted AND another master requests;
//     cleared on owner change or when no other request; saturates at MAX_HOLD.
//   - hold_cnt == MAX_HOLD AND m_as == `AS_DISABLE -> forced rotation to next requester
//     (owner's req ignored that edge); never preempt while m_as == `AS_ENABLE.
//  BUS_ARB_TIMEOUT_EN undefined: no counter, no m_as use; owner holds indefinitely.
// STRUCTURE
//  - bush.v: `REQ_ENABLE/`REQ_DISABLE, `GRANT_ENABLE/`GRANT_DISABLE, `AS_ENABLE/`AS_DISABLE,
//    `BUS_OWNER_W (2), `BUS_OWNER_M0..M3 encodings; add missing ones there, not locally.
//  - Single module; next-owner rotation as a function, no sub-module.
// TESTING
//  1 reset asserted mid-run with owner=2 -> same cycle m0_grant enabled, arb_owner=0.
//  2 idle, m2_req only -> next edge owner=2; m2 holds 50 cycles -> grant stays m2.
//  3 owner=1, m1 releases with m0,m2,m3 requesting -> owner=2 (rotation, not priority).
//  4 owner=3 releases, only m0 requests -> wrap, owner=0 in 1 cycle.
//  5 all reqs drop with owner=2 -> owner stays 2, m2_grant remains enabled.
//  6 TIMEOUT_EN, MAX_HOLD=16: m0 holds, m1 req from cycle 0, m_as enabled to cycle 20
//    -> no preempt until m_as disables at 21, then owner=1 next edge; TIMEOUT_EN off -> m0 keeps bus.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared encodings and next-owner rotation for the four-master bus arbiter.
package bus_arbiter_pkg;

    localparam logic REQ_ENABLE    = 1'b1;
    localparam logic REQ_DISABLE   = 1'b0;
    localparam logic GRANT_ENABLE  = 1'b1;
    localparam logic GRANT_DISABLE = 1'b0;
    localparam logic AS_ENABLE     = 1'b1;
    localparam logic AS_DISABLE    = 1'b0;

    localparam int BUS_OWNER_W = 2;

    typedef logic [BUS_OWNER_W-1:0] owner_t;

    localparam owner_t BUS_OWNER_M0 = 2'd0;
    localparam owner_t BUS_OWNER_M1 = 2'd1;
    localparam owner_t BUS_OWNER_M2 = 2'd2;
    localparam owner_t BUS_OWNER_M3 = 2'd3;

    // Owner keeps the bus while requesting, unless a forced rotation skips it.
    function automatic owner_t next_owner(
        input owner_t     cur,
        input logic [3:0] req,
        input logic       force_rot
    );
        owner_t nxt;
        owner_t cand;
        logic   found;
        nxt   = cur;
        found = 1'b0;
        if (req[cur] == REQ_ENABLE && !force_rot) begin
            found = 1'b1;
        end
        for (int i = 1; i < 4; i++) begin
            cand = cur + owner_t'(i);
            if (!found && req[cand] == REQ_ENABLE) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for bus masters m0..m3, grant parked on last owner.
// Optional hold timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m3_req,
    input  logic       m_as,
    output logic       m0_grant,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       m3_grant,
    output logic [1:0] arb_owner
);

    owner_t     owner;
    owner_t     nxt;
    logic [3:0] req;
    logic       force_rot;

    assign req = {m3_req, m2_req, m1_req, m0_req};

`ifdef BUS_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              others_req;

    always_comb begin
        others_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (owner_t'(i) != owner && req[i] == REQ_ENABLE) begin
                others_req = 1'b1;
            end
        end
    end

    // Never preempt in the middle of a transfer.
    assign force_rot = (hold_cnt == HOLD_W'(MAX_HOLD)) &&
                       (m_as == AS_DISABLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (nxt != owner || !others_req) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    logic unused_as;
    assign unused_as = m_as;
    assign force_rot = 1'b0;
`endif

    assign nxt = next_owner(owner, req, force_rot);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= BUS_OWNER_M0;
        end else begin
            owner <= nxt;
        end
    end

    assign m0_grant  = (owner == BUS_OWNER_M0) ? GRANT_ENABLE : GRANT_DISABLE;
    assign m1_grant  = (owner == BUS_OWNER_M1) ? GRANT_ENABLE : GRANT_DISABLE;
    assign m2_grant  = (owner == BUS_OWNER_M2) ? GRANT_ENABLE : GRANT_DISABLE;
    assign m3_grant  = (owner == BUS_OWNER_M3) ? GRANT_ENABLE : GRANT_DISABLE;
    assign arb_owner = owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, corner sequences,
// and random traffic against a round-robin reference model.
module tb_bus_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       reset;
    logic       m0_req, m1_req, m2_req, m3_req;
    logic       m_as;
    logic       m0_grant, m1_grant, m2_grant, m3_grant;
    logic [1:0] arb_owner;

    int n_checks = 0;
    int n_fail   = 0;

    int mdl_owner = 0;
    int mdl_wait  = 0;

    typedef struct {
        logic [3:0] req;
        logic       as_v;
        int         exp_owner;
    } vec_t;

    vec_t vecs[12];

    bus_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m2_req   (m2_req),
        .m3_req   (m3_req),
        .m_as     (m_as),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .m2_grant (m2_grant),
        .m3_grant (m3_grant),
        .arb_owner(arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: owner keeps bus while requesting; else first requester
    // in rotation order after it; nobody requesting -> park.
    task automatic model_edge(input logic [3:0] r, input logic a);
        int  old;
        bit  force_rot;
        bit  others;
        old       = mdl_owner;
        force_rot = 0;
`ifdef BUS_ARB_TIMEOUT_EN
        force_rot = (mdl_wait >= MAX_HOLD) && (a == 1'b0);
`else
        if (a) force_rot = 0;
`endif
        if (!(r[old] && !force_rot)) begin
            for (int k = 1; k <= 3; k++) begin
                if (r[(old + k) % 4]) begin
                    mdl_owner = (old + k) % 4;
                    break;
                end
            end
        end
        others = 0;
        for (int m = 0; m < 4; m++)
            if (m != old && r[m]) others = 1;
        if (mdl_owner != old || !others) mdl_wait = 0;
        else if (mdl_wait < MAX_HOLD) mdl_wait++;
    endtask

    task automatic check(input string name, input int exp);
        logic [3:0] g;
        logic [3:0] eg;
        g  = {m3_grant, m2_grant, m1_grant, m0_grant};
        eg = 4'b0001 << exp;
        n_checks++;
        if (arb_owner !== 2'(exp) || g !== eg) begin
            n_fail++;
            $display("FAIL %s: owner=%0d grants=%b, expected owner=%0d grants=%b",
                     name, arb_owner, g, exp, eg);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic a);
        {m3_req, m2_req, m1_req, m0_req} = r;
        m_as = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {m3_req, m2_req, m1_req, m0_req} = 4'b0000;
        m_as = 1'b0;
        @(posedge clk);
        #1;
        check("reset_state", 0);
        reset     = 1'b0;
        mdl_owner = 0;
        mdl_wait  = 0;
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 2};
        vecs[1]  = '{4'b0100, 1'b0, 2};
        vecs[2]  = '{4'b0000, 1'b0, 2};
        vecs[3]  = '{4'b1010, 1'b0, 3};
        vecs[4]  = '{4'b1011, 1'b0, 3};
        vecs[5]  = '{4'b0011, 1'b0, 0};
        vecs[6]  = '{4'b0110, 1'b0, 1};
        vecs[7]  = '{4'b1101, 1'b1, 2};
        vecs[8]  = '{4'b1000, 1'b0, 3};
        vecs[9]  = '{4'b0001, 1'b0, 0};
        vecs[10] = '{4'b0000, 1'b1, 0};
        vecs[11] = '{4'b0010, 1'b0, 1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].req, vecs[i].as_v);
            check($sformatf("vec%0d", i), vecs[i].exp_owner);
        end

        // m2 alone from idle, then held for 50 cycles.
        do_reset();
        step(4'b0100, 1'b0);
        check("m2_take", 2);
        for (int i = 0; i < 50; i++) begin
            step(4'b0100, 1'b0);
            if (i % 10 == 9) check($sformatf("m2_hold%0d", i), 2);
        end

        // Everyone drops: bus parks on m2.
        step(4'b0000, 1'b0);
        check("park_m2", 2);
        step(4'b0000, 1'b0);
        check("park_m2_b", 2);

        // Asynchronous reset mid-cycle while m2 owns the bus.
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mdl_owner = 0;
        mdl_wait  = 0;

        // Release with simultaneous requesters from owner 1 and 3.
        step(4'b0010, 1'b0);
        check("own1", 1);
        step(4'b1101, 1'b0);
        check("rotate_1_to_2", 2);
        step(4'b1000, 1'b0);
        check("to3", 3);
        step(4'b0001, 1'b0);
        check("wrap_3_to_0", 0);

        // m0 holds, m1 waits; transfer active through cycle 20.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            step(4'b0011, 1'b1);
            check($sformatf("hold_as_c%0d", c), 0);
        end
        step(4'b0011, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
        check("timeout_preempt", 1);
`else
        check("no_timeout_keep", 0);
`endif

        // Random traffic against the model; owner's req biased to stay.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r[mdl_owner] = 1'b1;
            step(r, 1'($urandom_range(0, 1)));
            check("random", mdl_owner);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
